// File: rtl/term_write_ctrl.sv
// Write sequencer for the 71x30 text-mode character RAM: cursor, scrolling and clears.
// Optional build macro TERM_BLINK_EN adds a blinking cursor; without it cur_vis is tied high.
module term_write_ctrl #(
    parameter int COLS         = 71,
    parameter int ROWS         = 30,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [7:0]  key_ascii,
    output logic        key_ready,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic [11:0] cur,
    output logic [4:0]  row_base,
    output logic        busy,
    output logic        cur_vis
);

    localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
    localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
    localparam logic [5:0]  ROWS_P   = 6'(ROWS);
    localparam logic [11:0] COLS_A   = 12'(COLS);
    localparam logic [12:0] COLS_C   = 13'(COLS);
    localparam logic [12:0] TOTAL_C  = 13'(COLS * ROWS);
    localparam logic [7:0]  SPACE    = 8'h20;

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, CLR_LINE = 2'd2, CLR_ALL = 2'd3} state_t;

    state_t      state_r, state_n;
    logic [4:0]  row_r, row_n, rb_r, rb_n, rb_inc_s;
    logic [6:0]  col_r, col_n;
    logic [12:0] cnt_r, cnt_n;
    logic [11:0] clr_base_r, clr_base_n;
    logic        scroll_pend_r, scroll_pend_n;

    logic        ram_we_r, ram_we_n, key_ready_r, key_ready_n, busy_r, busy_n;
    logic [11:0] ram_addr_r, ram_addr_n, cur_r, cur_n;
    logic [7:0]  ram_din_r, ram_din_n;

    logic accept_s, is_print_s, is_nl_s, is_bs_s, is_ff_s;

    // Physical RAM address of a logical cell, folding the circular row offset.
    function automatic logic [11:0] phys_addr(input logic [4:0] rb, input logic [4:0] r,
                                              input logic [6:0] c);
        logic [5:0] p;
        p = {1'b0, rb} + {1'b0, r};
        if (p >= ROWS_P) begin
            p = p - ROWS_P;
        end else begin
            p = p;
        end
        return 12'(p) * COLS_A + 12'(c);
    endfunction

    assign accept_s   = key_valid & key_ready_r;
    assign is_print_s = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
    assign is_nl_s    = (key_ascii == 8'h0D) || (key_ascii == 8'h0A);
    assign is_bs_s    = (key_ascii == 8'h08);
    assign is_ff_s    = (key_ascii == 8'h0C);
    assign rb_inc_s   = (rb_r == ROW_LAST) ? 5'd0 : rb_r + 5'd1;

    // State and cursor registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= CLR_ALL;
            row_r         <= 5'd0;
            col_r         <= 7'd0;
            rb_r          <= 5'd0;
            cnt_r         <= 13'd0;
            clr_base_r    <= 12'd0;
            scroll_pend_r <= 1'b0;
        end else begin
            state_r       <= state_n;
            row_r         <= row_n;
            col_r         <= col_n;
            rb_r          <= rb_n;
            cnt_r         <= cnt_n;
            clr_base_r    <= clr_base_n;
            scroll_pend_r <= scroll_pend_n;
        end
    end

    // Next state, key dispatch and cursor movement.
    always_comb begin
        state_n       = state_r;
        row_n         = row_r;
        col_n         = col_r;
        rb_n          = rb_r;
        cnt_n         = cnt_r;
        clr_base_n    = clr_base_r;
        scroll_pend_n = scroll_pend_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_n = IDLE;
                end else if (is_print_s) begin
                    state_n       = WRITE;
                    scroll_pend_n = 1'b0;
                    if (col_r != COL_LAST) begin
                        col_n = col_r + 7'd1;
                    end else if (row_r != ROW_LAST) begin
                        col_n = 7'd0;
                        row_n = row_r + 5'd1;
                    end else begin
                        // Wrap at the last cell: the old top row becomes the new bottom row.
                        col_n         = 7'd0;
                        rb_n          = rb_inc_s;
                        clr_base_n    = phys_addr(rb_r, 5'd0, 7'd0);
                        scroll_pend_n = 1'b1;
                    end
                end else if (is_nl_s) begin
                    col_n = 7'd0;
                    if (row_r != ROW_LAST) begin
                        row_n = row_r + 5'd1;
                    end else begin
                        rb_n       = rb_inc_s;
                        clr_base_n = phys_addr(rb_r, 5'd0, 7'd0);
                        cnt_n      = 13'd1;
                        state_n    = CLR_LINE;
                    end
                end else if (is_bs_s) begin
                    if (col_r != 7'd0) begin
                        col_n   = col_r - 7'd1;
                        state_n = WRITE;
                    end else if (row_r != 5'd0) begin
                        row_n   = row_r - 5'd1;
                        col_n   = COL_LAST;
                        state_n = WRITE;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (is_ff_s) begin
                    row_n   = 5'd0;
                    col_n   = 7'd0;
                    rb_n    = 5'd0;
                    cnt_n   = 13'd1;
                    state_n = CLR_ALL;
                end else begin
                    state_n = IDLE;
                end
            end
            WRITE: begin
                if (scroll_pend_r) begin
                    state_n       = CLR_LINE;
                    cnt_n         = 13'd1;
                    scroll_pend_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            CLR_LINE: begin
                if (cnt_r == COLS_C) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_r + 13'd1;
                end
            end
            CLR_ALL: begin
                if (cnt_r == TOTAL_C) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_r + 13'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; cnt counts writes already issued.
    always_comb begin
        ram_we_n    = 1'b0;
        ram_addr_n  = ram_addr_r;
        ram_din_n   = ram_din_r;
        cur_n       = phys_addr(rb_n, row_n, col_n);
        key_ready_n = (state_n == IDLE);
        busy_n      = (state_n == CLR_ALL);
        case (state_r)
            IDLE: begin
                if (accept_s && is_print_s) begin
                    ram_we_n   = 1'b1;
                    ram_addr_n = cur_r;
                    ram_din_n  = key_ascii;
                end else if (accept_s && (state_n == WRITE)) begin
                    ram_we_n   = 1'b1;
                    ram_addr_n = cur_n;
                    ram_din_n  = SPACE;
                end else if (accept_s && (state_n == CLR_LINE)) begin
                    ram_we_n   = 1'b1;
                    ram_addr_n = clr_base_n;
                    ram_din_n  = SPACE;
                end else if (accept_s && (state_n == CLR_ALL)) begin
                    ram_we_n   = 1'b1;
                    ram_addr_n = 12'd0;
                    ram_din_n  = SPACE;
                end else begin
                    ram_we_n = 1'b0;
                end
            end
            WRITE: begin
                if (state_n == CLR_LINE) begin
                    ram_we_n   = 1'b1;
                    ram_addr_n = clr_base_r;
                    ram_din_n  = SPACE;
                end else begin
                    ram_we_n = 1'b0;
                end
            end
            CLR_LINE: begin
                if (state_n == CLR_LINE) begin
                    ram_we_n   = 1'b1;
                    ram_addr_n = clr_base_r + cnt_r[11:0];
                    ram_din_n  = SPACE;
                end else begin
                    ram_we_n = 1'b0;
                end
            end
            CLR_ALL: begin
                if (state_n == CLR_ALL) begin
                    ram_we_n   = 1'b1;
                    ram_addr_n = cnt_r[11:0];
                    ram_din_n  = SPACE;
                end else begin
                    ram_we_n = 1'b0;
                end
            end
            default: begin
                ram_we_n = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we_r    <= 1'b0;
            ram_addr_r  <= 12'd0;
            ram_din_r   <= 8'd0;
            cur_r       <= 12'd0;
            key_ready_r <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            ram_we_r    <= ram_we_n;
            ram_addr_r  <= ram_addr_n;
            ram_din_r   <= ram_din_n;
            cur_r       <= cur_n;
            key_ready_r <= key_ready_n;
            busy_r      <= busy_n;
        end
    end

    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_din   = ram_din_r;
    assign cur       = cur_r;
    assign key_ready = key_ready_r;
    assign busy      = busy_r;
    assign row_base  = rb_r;

`ifdef TERM_BLINK_EN
    localparam int            BW         = $clog2(BLINK_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] blink_cnt_r;
    logic          cur_vis_r;

    // Blink timer: runs while idle, restarts lit on every accepted key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_r <= '0;
            cur_vis_r   <= 1'b1;
        end else if (accept_s) begin
            blink_cnt_r <= '0;
            cur_vis_r   <= 1'b1;
        end else if (state_r == IDLE) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r <= '0;
                cur_vis_r   <= ~cur_vis_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + 1'b1;
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
        end
    end

    assign cur_vis = cur_vis_r;
`else
    if (BLINK_CYCLES < 1) begin : g_blink_period_unused
    end

    assign cur_vis = 1'b1;
`endif

endmodule

// File: tb/tb_term_write_ctrl.sv
// Scoreboard bench for term_write_ctrl: a cell/cursor model queues expected RAM writes,
// a monitor pops them on every ram_we cycle.
module tb_term_write_ctrl;

    localparam int COLS = 71;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [7:0]  key_ascii = 8'h00;
    logic        key_ready, ram_we, busy, cur_vis;
    logic [11:0] ram_addr, cur;
    logic [7:0]  ram_din;
    logic [4:0]  row_base;

    term_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_CYCLES(12500000)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ascii(key_ascii),
        .key_ready(key_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .cur(cur), .row_base(row_base), .busy(busy), .cur_vis(cur_vis)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int din; bit busy;} wr_t;
    wr_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int m_row = 0, m_col = 0, m_rb = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int m_cur();
        return ((m_rb + m_row) % ROWS) * COLS + m_col;
    endfunction

    function automatic void push_wr(input int a, input int d, input bit b);
        wr_t w;
        w.addr = a; w.din = d; w.busy = b;
        exp_q.push_back(w);
    endfunction

    function automatic void model_newline(inout int nw);
        m_col = 0;
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            m_rb = (m_rb + 1) % ROWS;
            for (int k = 0; k < COLS; k++) push_wr(((m_rb + ROWS - 1) % ROWS) * COLS + k, 32'h20, 1'b0);
            nw += COLS;
        end
    endfunction

    // Terminal model: updates cursor/offset and queues the writes a key must cause.
    function automatic int model_key(input logic [7:0] c);
        int nw = 0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_wr(m_cur(), int'(c), 1'b0);
            nw = 1;
            m_col++;
            if (m_col == COLS) model_newline(nw);
        end else if (c == 8'h0D || c == 8'h0A) begin
            model_newline(nw);
        end else if (c == 8'h08) begin
            if (m_col > 0 || m_row > 0) begin
                if (m_col > 0) m_col--;
                else begin m_row--; m_col = COLS - 1; end
                push_wr(m_cur(), 32'h20, 1'b0);
                nw = 1;
            end
        end else if (c == 8'h0C) begin
            m_row = 0; m_col = 0; m_rb = 0;
            for (int k = 0; k < COLS * ROWS; k++) push_wr(k, 32'h20, 1'b1);
            nw = COLS * ROWS;
        end
        return nw;
    endfunction

    // Monitor: every RAM write must be the next one the model expects.
    always @(negedge clk) begin
        if (rst && ram_we) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d din %0h, none expected", ram_addr, ram_din);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", ram_addr, w.addr);
                check("wr_din", ram_din, w.din);
                check("wr_busy", busy, w.busy);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        step();
        while ((!key_ready || exp_q.size() != 0) && t < 6000) begin
            step();
            t++;
        end
        check("idle_timeout", key_ready, 1);
        check("pending_writes", exp_q.size(), 0);
    endtask

    task automatic send_key(input logic [7:0] c, output int nw);
        int t = 0;
        nw = 0;
        step();
        while (!key_ready && t < 6000) begin
            step();
            t++;
        end
        if (!key_ready) begin
            check("ready_timeout", key_ready, 1);
            return;
        end
        key_valid = 1'b1;
        key_ascii = c;
        nw = model_key(c);
        @(posedge clk);
        #1 key_valid = 1'b0;
        step();
        check("cur", cur, m_cur());
        check("row_base", row_base, m_rb);
        check("key_ready_after", key_ready, (nw == 0) ? 1 : 0);
        check("busy_after", busy, (c == 8'h0C) ? 1 : 0);
        check("cur_vis", cur_vis, 1);
        if (nw == 1) begin
            step();
            check("ready_after_write", key_ready, 1);
        end
    endtask

    task automatic send(input logic [7:0] c);
        int nw;
        send_key(c, nw);
    endtask

    // Offer a key while the controller is busy; it must vanish without effect.
    task automatic drop_key(input logic [7:0] c);
        check("drop_not_ready", key_ready, 0);
        key_valid = 1'b1;
        key_ascii = c;
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        key_valid = 1'b0;
        exp_q.delete();
        m_row = 0; m_col = 0; m_rb = 0;
        #2;
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_cur", cur, 0);
        check("rst_row_base", row_base, 0);
        check("rst_key_ready", key_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_cur_vis", cur_vis, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < COLS * ROWS; k++) push_wr(k, 32'h20, 1'b1);
        wait_idle();
        check("post_clear_cur", cur, 0);
        check("post_clear_busy", busy, 0);
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32'h20, 32'h7E));
    endfunction

    initial begin
        int nw;
        logic [7:0] c;
        do_reset();

        send(8'h41);
        check("cur_after_A", cur, 1);
        for (int i = 0; i < 70; i++) send(rand_print());
        check("cur_after_row", cur, 71);
        send(8'h08);
        check("cur_after_bs", cur, 70);

        send(8'h0C);
        wait_idle();
        send(8'h08);
        check("cur_bs_at_origin", cur, 0);

        for (int i = 0; i < 29; i++) send(8'h0D);
        for (int i = 0; i < 5; i++) send(rand_print());
        check("cur_row29_col5", cur, 29 * 71 + 5);
        send_key(8'h0D, nw);
        drop_key(8'h42);
        wait_idle();
        check("cur_after_scroll", cur, 0);
        check("row_base_after_scroll", row_base, 1);

        for (int i = 0; i < 71; i++) send(rand_print());
        wait_idle();
        check("row_base_after_wrap", row_base, 2);
        check("cur_after_wrap", cur, 71);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60) c = rand_print();
            else if (r < 75) c = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
            else if (r < 93) c = 8'h08;
            else if (r < 99) begin
                c = 8'($urandom_range(0, 255));
                if ((c >= 8'h20 && c <= 8'h7E) || c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D)
                    c = 8'h7F;
            end else c = 8'h0C;
            send_key(c, nw);
            if (nw > 1 && $urandom_range(0, 1) != 0) drop_key(rand_print());
            repeat ($urandom_range(0, 2)) step();
        end
        wait_idle();

        send(8'h0C);
        repeat (300) step();
        do_reset();
        send(8'h41);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
